// File: rtl/pu_stream_feeder.sv
// pu_stream_feeder: streams buffer words into a fixed-latency, non-stalling
// 4-lane PU and gathers its results into a valid/ready FIFO. Issue is
// credit-gated so a PU result always finds a free FIFO slot.
module pu_stream_feeder #(
  parameter int DATA_W     = 5,
  parameter int ADDR_W     = 6,
  parameter int OUT_W      = 12,
  parameter int PU_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_load,
  input  logic [4*DATA_W-1:0] w_in,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [4*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]   pu_in1,
  output logic [DATA_W-1:0]   pu_in2,
  output logic [DATA_W-1:0]   pu_in3,
  output logic [DATA_W-1:0]   pu_in4,
  output logic [DATA_W-1:0]   pu_w1,
  output logic [DATA_W-1:0]   pu_w2,
  output logic [DATA_W-1:0]   pu_w3,
  output logic [DATA_W-1:0]   pu_w4,
  input  logic [OUT_W-1:0]    pu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUT_W-1:0]    res_data,
  output logic                res_last,
  output logic                busy,
  output logic                done
);
  // vld/last pipe is STAGES+1 deep: slot 0 = data on PU inputs, slot STAGES = pu_out valid
  localparam int STAGES = PU_LAT;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + STAGES + 2) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remain;
  logic [4*DATA_W-1:0] r_wgt;
  logic [STAGES:0]     r_vld_pipe, r_last_pipe;
  logic                r_zero_done;
  logic [OUT_W:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [PW:0]         r_cnt;

  logic [CW-1:0]       w_inflight, w_occ;
  logic                w_issue, w_issue_last, w_push, w_pop, w_full, w_fin;
  logic [4*DATA_W-1:0] w_lanes;

  // results still travelling through the PU
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= STAGES; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // a word may issue only if its result is guaranteed a FIFO slot
  assign w_occ        = CW'(r_cnt) + w_inflight;
  assign w_issue      = (r_state == RUN) && (r_remain != '0) && (w_occ < CW'(FIFO_DEPTH));
  assign w_issue_last = w_issue && (r_remain == (ADDR_W+1)'(1));
  assign w_push       = r_vld_pipe[STAGES];
  assign w_full       = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign res_valid    = (r_cnt != '0);
  assign w_pop        = res_valid && res_ready;
  assign {res_last, res_data} = r_mem[r_rp];
  assign w_fin        = (r_state == DRAIN) && (w_inflight == '0) && w_pop && res_last;

  assign rd_en   = w_issue;
  assign rd_addr = w_issue ? r_addr : '0;
  assign w_lanes = r_vld_pipe[0] ? rd_data : '0;
  assign pu_in1  = w_lanes[0*DATA_W +: DATA_W];
  assign pu_in2  = w_lanes[1*DATA_W +: DATA_W];
  assign pu_in3  = w_lanes[2*DATA_W +: DATA_W];
  assign pu_in4  = w_lanes[3*DATA_W +: DATA_W];
  assign pu_w1   = r_wgt[0*DATA_W +: DATA_W];
  assign pu_w2   = r_wgt[1*DATA_W +: DATA_W];
  assign pu_w3   = r_wgt[2*DATA_W +: DATA_W];
  assign pu_w4   = r_wgt[3*DATA_W +: DATA_W];
  assign busy    = (r_state != IDLE);
  assign done    = r_zero_done | w_fin;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state: RUN until the last word issues, DRAIN until its result is taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start && (count != '0)) w_state_nxt = RUN;
      RUN:     if (w_issue_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_fin) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // job setup in IDLE (weights, address, length); walk address/length per issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_wgt       <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= (r_state == IDLE) && start && (count == '0);
      if (r_state == IDLE) begin
        if (w_load) r_wgt <= w_in;
        if (start) begin
          r_addr   <= base_addr;
          r_remain <= count;
        end
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - (ADDR_W+1)'(1);
      end
    end
  end

  // valid/last shift register tracking each issued word through the PU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:0], w_issue};
      r_last_pipe <= {r_last_pipe[STAGES-1:0], w_issue_last};
    end
  end

  // result FIFO: push on pu_out valid, pop on handshake, both may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {r_last_pipe[STAGES], pu_out};
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // the PU cannot be stalled, so a result arriving at a full FIFO would be lost
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_pu_stream_feeder.sv
// Bench for pu_stream_feeder: behavioural buffer and PU around the DUT,
// a queue-based scoreboard for addresses/results, table vectors and corner cases.
module tb_pu_stream_feeder;
  localparam int DW = 5;
  localparam int AW = 6;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_load = 1'b0;
  logic [4*DW-1:0] w_in = '0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [4*DW-1:0] rd_data = '0;
  logic [DW-1:0] pu_in1, pu_in2, pu_in3, pu_in4, pu_w1, pu_w2, pu_w3, pu_w4;
  logic [OW-1:0] pu_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_data;
  logic          res_last, busy, done;

  always #5 clk = ~clk;

  pu_stream_feeder dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .start(start),
    .base_addr(base_addr), .count(count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pu_in1(pu_in1), .pu_in2(pu_in2), .pu_in3(pu_in3),
    .pu_in4(pu_in4), .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3), .pu_w4(pu_w4),
    .pu_out(pu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int done_cnt = 0;
  logic [4*DW-1:0] mem [64];
  logic [4*DW-1:0] model_w = '0;
  logic [AW-1:0]   exp_addr [$];
  logic [OW:0]     exp_res [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // signed 4-lane dot product, wrapped to the result width
  function automatic logic [OW-1:0] dot4(input logic [4*DW-1:0] a, input logic [4*DW-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [DW-1:0] x, y;
      int xi, yi;
      x = a[i*DW +: DW];
      y = w[i*DW +: DW];
      xi = x;
      yi = y;
      s += xi * yi;
    end
    return s[OW-1:0];
  endfunction

  function automatic logic [4*DW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {l3[DW-1:0], l2[DW-1:0], l1[DW-1:0], l0[DW-1:0]};
  endfunction

  // processing unit: two register stages, reset together with the feeder
  logic [OW-1:0] pu_s1, pu_s2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pu_s1 <= '0;
      pu_s2 <= '0;
    end else begin
      pu_s1 <= dot4({pu_in4, pu_in3, pu_in2, pu_in1}, {pu_w4, pu_w3, pu_w2, pu_w1});
      pu_s2 <= pu_s1;
    end
  end
  assign pu_out = pu_s2;

  // input buffer: data one cycle after rd_en, junk otherwise
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : (4*DW)'($urandom);

  // scoreboard / protocol monitor, sampled on the falling edge
  initial begin
    logic hold_v, prev_rd;
    logic [OW:0] hold_d;
    logic [AW-1:0] prev_addr;
    hold_v = 1'b0; prev_rd = 1'b0; hold_d = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        prev_rd = 1'b0;
      end else begin
        check("pu_w", {pu_w4, pu_w3, pu_w2, pu_w1}, model_w);
        check("pu_in", {pu_in4, pu_in3, pu_in2, pu_in1}, prev_rd ? mem[prev_addr] : '0);
        if (rd_en) begin
          n_rd++;
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_rd: read of %0d, none expected", rd_addr);
          end else check("rd_addr", rd_addr, exp_addr.pop_front());
        end
        if (hold_v) begin
          check("hold_valid", res_valid, 1);
          check("hold_data", {res_last, res_data}, hold_d);
        end
        if (res_valid && res_ready) begin
          if (exp_res.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_res: got %0h, none expected", {res_last, res_data});
          end else check("result", {res_last, res_data}, exp_res.pop_front());
        end
        if (done) done_cnt++;
        hold_v = res_valid && !res_ready;
        hold_d = {res_last, res_data};
        prev_rd = rd_en;
        prev_addr = rd_addr;
      end
    end
  end

  task automatic chk_zero(input string n);
    check({n, "_ctl"}, {rd_en, rd_addr, res_valid, res_last, busy, done}, 0);
    check({n, "_pu_in"}, {pu_in4, pu_in3, pu_in2, pu_in1}, 0);
    check({n, "_pu_w"}, {pu_w4, pu_w3, pu_w2, pu_w1}, 0);
    check({n, "_data"}, res_data, 0);
  endtask

  task automatic load_w(input logic [4*DW-1:0] w);
    w_in = w; w_load = 1'b1;
    @(posedge clk);
    model_w = w;
    #1 w_load = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_res.push_back({(i == n - 1), dot4(mem[a], model_w)});
    end
    base_addr = b; count = (AW+1)'(n); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit rnd, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt; seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (rnd) res_ready = ($urandom_range(3) != 0);
      if (done_cnt != d0) begin seen = 1'b1; break; end
    end
    check({name, "_done"}, seen, 1);
    check({name, "_drained"}, exp_res.size() + exp_addr.size(), 0);
  endtask

  typedef struct {
    logic [4*DW-1:0] w;
    logic [4*DW-1:0] d;
    logic [OW-1:0]   exp;
  } vec_t;

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: run exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int d0, n0;
    bit found;
    for (int i = 0; i < 64; i++) mem[i] = (4*DW)'($urandom);
    tbl[0] = '{pack(1, 2, 3, 4),     pack(1, 1, 1, 1),     12'h00A};
    tbl[1] = '{pack(-16, -16, -16, -16), pack(-16, -16, -16, -16), 12'h400};
    tbl[2] = '{pack(-16, -16, -16, -16), pack(15, 15, 15, 15), 12'hC40};
    tbl[3] = '{pack(1, -1, 2, -2),   pack(5, 5, 5, 5),     12'h000};
    tbl[4] = '{pack(15, 15, 15, 15), pack(15, 15, 15, 15), 12'h384};
    tbl[5] = '{pack(-1, 0, 0, 0),    pack(7, 3, -2, 9),    12'hFF9};
    tbl[6] = '{pack(3, -4, 5, -6),   pack(-7, 2, -3, 1),   12'hFCE};

    #12 chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk_zero("idle");

    // single-word jobs: latency and value from the table
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [AW-1:0] b;
      b = AW'($urandom);
      load_w(tbl[i].w);
      mem[b] = tbl[i].d;
      start_job(b, 1);
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rd_en) begin found = 1'b1; break; end
      end
      check("tbl_rd", found, 1);
      repeat (3) @(negedge clk);
      check("tbl_early", res_valid, 0);
      @(negedge clk);
      check("tbl_valid", res_valid, 1);
      check("tbl_data", res_data, tbl[i].exp);
      check("tbl_last", res_last, 1);
      check("tbl_done", done, 1);
      @(negedge clk);
      check("tbl_idle", {done, busy, res_valid}, 0);
    end

    // zero-length job
    n0 = n_rd; d0 = done_cnt;
    start_job(AW'($urandom), 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_pulse", {done, busy}, 0);
    check("zero_reads", n_rd - n0, 0);

    // back-pressure: only FIFO_DEPTH words may be issued
    load_w((4*DW)'($urandom));
    res_ready = 1'b0; n0 = n_rd;
    start_job(AW'($urandom), 8);
    repeat (20) @(negedge clk);
    check("bp_reads", n_rd - n0, 4);
    check("bp_valid", res_valid, 1);
    check("bp_busy", busy, 1);
    check("bp_pending", exp_res.size(), 8);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done("bp", 1'b0, 60);
    check("bp_total", n_rd - n0, 8);

    // address wrap with start/w_load attempted mid-job
    load_w((4*DW)'($urandom));
    n0 = n_rd;
    start_job(AW'(62), 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(5); count = (AW+1)'(3); w_load = 1'b1; w_in = ~model_w;
    @(posedge clk); #1;
    start = 1'b0; w_load = 1'b0;
    wait_done("wrap", 1'b1, 60);
    check("wrap_reads", n_rd - n0, 4);

    // reset with two results in flight and two buffered
    res_ready = 1'b0;
    load_w((4*DW)'($urandom));
    d0 = done_cnt; n0 = n_rd;
    start_job(AW'($urandom), 8);
    repeat (6) @(negedge clk);
    check("rst_issued", n_rd - n0, 4);
    check("rst_buffered", res_valid, 1);
    rst = 1'b1;
    model_w = '0;
    exp_addr.delete();
    exp_res.delete();
    #1 chk_zero("rst_mid");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("rst_after");
    check("rst_no_done", done_cnt - d0, 0);
    res_ready = 1'b1;
    load_w((4*DW)'($urandom));
    start_job(AW'($urandom), 3);
    wait_done("after_rst", 1'b1, 60);

    // randomized jobs against the scoreboard
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 64; i++) mem[i] = (4*DW)'($urandom);
      load_w((4*DW)'($urandom));
      start_job(AW'($urandom), $urandom_range(1, 12));
      wait_done("rand", 1'b1, 300);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
